pc_sequencer: RTL
=================

# pc_sequencer

Instruction-fetch and program-counter sequencer for the single-issue MIPS core. It owns the PC, fetches each instruction from instruction memory over a req/ready handshake, and presents the opcode field to the main control decoder. It consumes the decoder's control bus plus the ALU zero flag to select the next PC: sequential, taken beq branch, or j jump. It also keeps a retired-instruction count.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- imem_req  out  1  fetch request; high throughout FETCH.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  fetch completes on a cycle where imem_req && imem_ready.
- imem_rdata  in  32  instruction word; valid only when imem_ready is high.
- op  out  6  instr[31:26], driven to the control decoder.
- control_bus  in  9  decoder output: [8] RegDst, [7] ALUSrc, [6] MemToReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] Branch, [1:0] ALUOp.
- zero  in  1  ALU zero flag for the current instruction.
- stall  in  1  datapath hold request; freezes EXEC.
- instr  out  32  registered current instruction.
- instr_valid  out  1  high in EXEC; instr, op and the control bus are meaningful.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instret  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE → FETCH unconditionally on the next cycle.
- FETCH: imem_req = 1. On imem_req && imem_ready, capture instr <= imem_rdata and go to EXEC. Otherwise stay in FETCH.
- EXEC: instr_valid = 1.
  - If stall = 1: remain in EXEC and hold pc, instr and instret.
  - If stall = 0 (retire cycle): update pc, increment instret, go to FETCH.
- Next-PC priority at retire:
  1. Jump: op == 6'd2 is decoded locally; next = {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. Taken branch: control_bus[2] && zero; next = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  3. Otherwise: pc_plus4.
- Opcodes the decoder does not recognise get no special treatment; they fall through to pc_plus4.
- Arithmetic: all PC math is 32-bit and wraps modulo 2^32. For example, pc = 32'hFFFF_FFFC gives pc_plus4 = 0. Branch offsets are signed.
- instret is 32 bits and wraps from FFFF_FFFF to 0.
- control_bus bits other than [2] are ignored by this block.

## Timing
- Reset values:
  - state = IDLE, pc = RESET_PC, instr = 0, instret = 0.
  - imem_req = 0, instr_valid = 0, op = 0.
  - imem_addr = RESET_PC, pc_plus4 = RESET_PC + 4.
- Reset asserted in any state, including mid-fetch with imem_req high: the next edge forces the reset values. A pending fetch is abandoned and its imem_ready is ignored.
- After rst_n rises:
  - first edge: IDLE → FETCH;
  - imem_req is high from the following cycle.
- Minimum cost per instruction is 2 cycles: FETCH with ready already high, then EXEC with stall low. Each wait-state adds one cycle to FETCH. Each stall cycle adds one cycle to EXEC.
- imem_addr is stable for the whole FETCH state.
- imem_rdata is ignored outside FETCH.
- Outputs are registered state or combinational from state/registers; op tracks instr.
- Retire edge: pc, instret and state all update on the same edge. zero and control_bus are sampled only on that edge.
- stall is ignored in IDLE and FETCH.

## Test plan
- Reset/sequential:
  - Stimulus: RESET_PC = 0; imem_ready tied high; feed four add R-type words.
  - Required: imem_addr sequence 0, 4, 8, C; instr_valid pulses once every 2 cycles; instret = 4.
- Fetch wait-states:
  - Stimulus: imem_ready low for 3 cycles at addr 0x10.
  - Required: imem_req and imem_addr = 0x10 held for 4 cycles; instr captured only on the ready cycle.
- beq:
  - Stimulus: instr = 0x1000_FFFF at pc 0x20, control_bus = 9'b0000_00101.
  - Required: zero = 1 gives next pc 0x20; zero = 0 gives next pc 0x24.
- Jump and wrap:
  - Stimulus: j with target field 0x0000_040 at pc 0x8000_0000; separately, a sequential instruction at pc 32'hFFFF_FFFC.
  - Required: next pc = 0x8000_0100; the sequential case gives next pc = 0.
- Stall:
  - Stimulus: stall high for 5 cycles in EXEC during a taken branch, with zero high only on the final cycle.
  - Required: pc and instret frozen for all 5 cycles; branch taken on release.
- Mid-fetch reset:
  - Stimulus: rst_n low for 1 cycle while in FETCH at pc 0x40, with imem_ready high on that same edge.
  - Required: pc = RESET_PC; instr = 0; instret = 0; no instr_valid pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer: fetches over a req/ready handshake,
// holds the instruction during execute, and picks jump / taken-branch / sequential next PC.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  op,
    input  logic [8:0]  control_bus,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    localparam logic [5:0] OP_J = 6'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic        unused_ctrl;

    function automatic logic [31:0] jump_target(input logic [31:0] seq, input logic [31:0] word);
        return {seq[31:28], word[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] seq, input logic [31:0] word);
        return seq + {{14{word[15]}}, word[15:0], 2'b00};
    endfunction

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign op          = instr[31:26];

    // Only the Branch bit matters here; the rest of the decoder bus is for the datapath.
    assign unused_ctrl = ^{control_bus[8:3], control_bus[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        if (op == OP_J) begin
            next_pc = jump_target(pc_plus4, instr);
        end else if (control_bus[2] && zero) begin
            next_pc = branch_target(pc_plus4, instr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'd0;
            instret <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Retire: PC, counter and state all advance on the same edge.
                    if (!stall) begin
                        pc      <= next_pc;
                        instret <= instret + 32'd1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
